// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU/UART frame sequencer.
//   - N_BITS_DEFAULT : default operand/byte width
//   - state_e        : FSM state encoding (also driven onto o_state)
//   - OP_*           : opcode values, compared zero-extended against the opcode byte
package alu_uart_sequencer_pkg;

  localparam int unsigned N_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

endpackage

// File: rtl/alu_uart_sequencer_alu.sv
// Combinational ALU used by the frame sequencer.
// Ports:
//   i_a, i_b   operands (i_b is the shift amount for SRL/SRA)
//   i_op       opcode byte
//   o_result   N_LEDS-wide result; 0 for an unknown opcode
//   o_op_err   1 when i_op is not a known opcode
module alu_uart_sequencer_alu
  import alu_uart_sequencer_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEFAULT,
  parameter int unsigned N_LEDS = N_BITS
) (
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  input  logic [N_BITS-1:0] i_op,
  output logic [N_LEDS-1:0] o_result,
  output logic              o_op_err
);

  // Opcode constants are 8 bits; compare at the wider of the two widths so the
  // opcode byte is zero-extended rather than truncated.
  localparam int unsigned OPW = (N_BITS > 8) ? N_BITS : 8;

  logic [OPW-1:0]    op_ext;
  logic [N_BITS-1:0] res;

  assign op_ext = OPW'(i_op);

  always_comb begin
    res      = '0;
    o_op_err = 1'b0;
    case (op_ext)
      OPW'(OP_ADD): res = i_a + i_b;
      OPW'(OP_SUB): res = i_a - i_b;
      OPW'(OP_AND): res = i_a & i_b;
      OPW'(OP_OR):  res = i_a | i_b;
      OPW'(OP_XOR): res = i_a ^ i_b;
      OPW'(OP_NOR): res = ~(i_a | i_b);
      OPW'(OP_SRL): res = i_a >> i_b;
      OPW'(OP_SRA): res = N_BITS'($signed(i_a) >>> i_b);
      default: begin
        res      = '0;
        o_op_err = 1'b1;
      end
    endcase
  end

  assign o_result = N_LEDS'(res);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between uart_rx/uart_tx and the ALU.
// Collects operand A, operand B and opcode bytes, executes once, registers the
// result and hands it to the transmitter.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_rx_data, i_rx_valid     received byte stream (no backpressure)
//   o_tx_data, o_tx_start     result byte and one-cycle transmit request
//   i_tx_busy, i_tx_done      transmitter status
//   o_op_err                  last executed opcode was unknown
//   o_overrun                 sticky: byte arrived while not collecting
//   o_state                   FSM state encoding
//
// state      | meaning
// WAIT_A     | idle, waiting for operand A
// WAIT_B     | waiting for operand B (timeout armed)
// WAIT_OP    | waiting for opcode (timeout armed)
// EXEC       | one cycle: register ALU result and error flag
// SEND       | request transmit once transmitter is idle
// WAIT_TX    | waiting for transmitter completion
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int unsigned N_BITS         = N_BITS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  input  logic              i_tx_done,
  output logic              o_op_err,
  output logic              o_overrun,
  output logic [2:0]        o_state
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [N_BITS-1:0] op_q, op_d;
  logic [N_BITS-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              op_err_q, op_err_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_BITS-1:0] alu_result;
  logic              alu_op_err;
  logic              timeout_hit;

  alu_uart_sequencer_alu #(
    .N_BITS (N_BITS),
    .N_LEDS (N_BITS)
  ) u_alu (
    .i_a      (a_q),
    .i_b      (b_q),
    .i_op     (op_q),
    .o_result (alu_result),
    .o_op_err (alu_op_err)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    op_err_d   = op_err_q;
    overrun_d  = overrun_q;
    cnt_d      = cnt_q;

    // Bytes arriving outside the collection states are dropped but flagged.
    if (i_rx_valid && (state_q inside {ST_EXEC, ST_SEND, ST_WAIT_TX})) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_WAIT_A: begin
        cnt_d = '0;
        if (i_rx_valid) begin
          a_d     = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_valid) begin
          b_d     = i_rx_data;
          cnt_d   = '0;
          state_d = ST_WAIT_OP;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = ST_WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_valid) begin
          op_d    = i_rx_data;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = ST_WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        tx_data_d = alu_result;
        op_err_d  = alu_op_err;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      op_err_q   <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      op_err_q   <= op_err_d;
      overrun_q  <= overrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_op_err   = op_err_q;
  assign o_overrun  = overrun_q;
  assign o_state    = state_q;

endmodule
